// File: rtl/tx_byte_queue.sv
`timescale 1ns/1ps
// Byte FIFO between the CPU transmit strobe and uart_tx; drains one byte per serializer frame.
// Latency: a push into an empty idle queue pops on the next edge; tx_dv pulses for one cycle.
// Backpressure: none upstream (a push while full is dropped and flagged); downstream waits on tx_done.
module tx_byte_queue #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              tx_active,
    input  logic              tx_done,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wp;
    logic [ADDR_W-1:0]   rp;
    logic                push;
    logic                pop;

    assign full  = (count == (ADDR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // full is the pre-edge value, so a pop on the same edge never makes room for a push
    assign push = wr_en && !full && !flush;
    assign pop  = (state == IDLE) && !empty && !tx_active && !flush;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Flush does not touch the drain sequence; an in-flight frame completes normally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    tx_dv <= 1'b0;
                    if (pop) begin
                        tx_byte <= mem[rp];
                        tx_dv   <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_dv <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    tx_dv <= 1'b0;
                    if (tx_done) begin
                        state <= GUARD;
                    end
                end
                GUARD: begin
                    tx_dv <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    tx_dv <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_byte_queue.sv
`timescale 1ns/1ps
// Directed bench for tx_byte_queue: reset, latency, ordering with wrap, overflow, flush, busy line.
module tb_tx_byte_queue;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       tx_active;
    logic       tx_done;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       full;
    logic       empty;
    logic [3:0] count;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    tx_byte_queue #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (flush),
        .tx_active (tx_active),
        .tx_done   (tx_done),
        .tx_dv     (tx_dv),
        .tx_byte   (tx_byte),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serializer acknowledges the current frame, then the GUARD cycle passes.
    task automatic finish_frame();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en     = 1'($urandom_range(0, 1));
            wr_data   = 8'($urandom_range(0, 255));
            flush     = 1'($urandom_range(0, 1));
            tx_active = 1'($urandom_range(0, 1));
            tx_done   = 1'($urandom_range(0, 1));
            tick();
        end
        wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
        rst = 1'b1;
        tick();
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL reset_tx_dv got %0b want 0", tx_dv); end
        n_cmp++; if (tx_byte !== 8'h00) begin n_err++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %0b want 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %0b want 0", full); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_single_byte();
        push_byte(8'h41);                                   // edge N
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_count_n got %0d want 1", count); end
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL single_dv_n got %0b want 0", tx_dv); end
        tick();                                             // edge N+1: pop
        n_cmp++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL single_dv_n1 got %0b want 1", tx_dv); end
        n_cmp++; if (tx_byte !== 8'h41) begin n_err++; $display("FAIL single_byte got %h want 41", tx_byte); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL single_count_n1 got %0d want 0", count); end
        tick();                                             // edge N+2
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL single_dv_n2 got %0b want 0", tx_dv); end
        push_byte(8'h42);                                   // edge N+3, FSM in WAIT
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL single_queued got %0d want 1", count); end
        for (int i = 0; i < 7; i++) begin                   // edges N+4..N+10
            tick();
            n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL single_wait_dv cyc %0d got %0b want 0", i, tx_dv); end
        end
        tx_done = 1'b1;
        tick();                                             // edge D: WAIT->GUARD
        tx_done = 1'b0;
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL single_guard_dv got %0b want 0", tx_dv); end
        n_cmp++; if (tx_byte !== 8'h41) begin n_err++; $display("FAIL single_byte_hold got %h want 41", tx_byte); end
        tick();                                             // edge D+1: GUARD->IDLE
        n_cmp++; if (tx_dv !== 1'b0 || count !== 4'd1) begin n_err++; $display("FAIL single_idle got dv=%0b cnt=%0d want dv=0 cnt=1", tx_dv, count); end
        tick();                                             // edge D+2: pop
        n_cmp++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL b2b_dv got %0b want 1", tx_dv); end
        n_cmp++; if (tx_byte !== 8'h42) begin n_err++; $display("FAIL b2b_byte got %h want 42", tx_byte); end
        n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL b2b_count got %0d want 0", count); end
        tick();
        finish_frame();
    endtask

    task automatic test_burst_wrap();
        tx_active = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'(i));
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL burst_full got %0b want 1", full); end
        n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL burst_count got %0d want 8", count); end
        n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL burst_dv got %0b want 0", tx_dv); end
        tx_active = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int t = 0; t < 10 && tx_dv !== 1'b1; t++) tick();
            n_cmp++; if (tx_dv !== 1'b1) begin n_err++; $display("FAIL burst_timeout byte %0d got dv=%0b want 1", k, tx_dv); end
            n_cmp++; if (tx_byte !== 8'(k)) begin n_err++; $display("FAIL burst_order got %h want %h", tx_byte, 8'(k)); end
            if (k < 4) begin
                push_byte(8'(8 + k));
                n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL burst_refill byte %0d got %0d want 8", k, count); end
            end else begin
                tick();
            end
            tx_done = 1'b1;
            tick();
            tx_done = 1'b0;
        end
        tick();
        n_cmp++; if (empty !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL burst_end got empty=%0b ovf=%0b want 1 0", empty, overflow); end
    endtask

    task automatic test_overflow();
        tx_active = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'hA0 + 8'(i));
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full got %0b want 1", full); end
        tx_active = 1'b0;
        push_byte(8'hFF);                                   // pop of A0 on the same edge
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %0b want 1", overflow); end
        n_cmp++; if (count !== 4'd7) begin n_err++; $display("FAIL ovf_count got %0d want 7", count); end
        n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA0) begin n_err++; $display("FAIL ovf_pop got dv=%0b byte=%h want 1 a0", tx_dv, tx_byte); end
        tick();
        finish_frame();
        for (int k = 1; k < 8; k++) begin
            for (int t = 0; t < 10 && tx_dv !== 1'b1; t++) tick();
            n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hA0 + 8'(k)) begin n_err++; $display("FAIL ovf_drain got dv=%0b byte=%h want 1 %h", tx_dv, tx_byte, 8'hA0 + 8'(k)); end
            tick();
            finish_frame();
        end
        for (int t = 0; t < 6; t++) begin
            tick();
            n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL ovf_ff_sent got dv=%0b byte=%h want no tx_dv", tx_dv, tx_byte); end
        end
        n_cmp++; if (overflow !== 1'b1 || empty !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got ovf=%0b empty=%0b want 1 1", overflow, empty); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) push_byte(8'hB0 + 8'(i)); // B0 goes in flight, B1..B5 queued
        n_cmp++; if (count !== 4'd5) begin n_err++; $display("FAIL flush_pre_count got %0d want 5", count); end
        flush = 1'b1;
        push_byte(8'h55);
        flush = 1'b0;
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL flush_count got cnt=%0d empty=%0b want 0 1", count, empty); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL flush_ovf got %0b want 0", overflow); end
        n_cmp++; if (tx_byte !== 8'hB0) begin n_err++; $display("FAIL flush_inflight got %h want b0", tx_byte); end
        finish_frame();
        for (int t = 0; t < 5; t++) begin
            tick();
            n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL flush_leak got dv=%0b byte=%h want no tx_dv", tx_dv, tx_byte); end
        end
        push_byte(8'hC0);
        tick();
        n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hC0) begin n_err++; $display("FAIL flush_resume got dv=%0b byte=%h want 1 c0", tx_dv, tx_byte); end
        tick();
        finish_frame();
    endtask

    task automatic test_busy_line();
        tx_active = 1'b1;
        push_byte(8'hD1);
        push_byte(8'hD2);
        for (int t = 0; t < 4; t++) begin
            tick();
            n_cmp++; if (tx_dv !== 1'b0) begin n_err++; $display("FAIL busy_dv got %0b want 0", tx_dv); end
        end
        n_cmp++; if (count !== 4'd2) begin n_err++; $display("FAIL busy_count got %0d want 2", count); end
        tx_active = 1'b0;
        tick();
        n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hD1) begin n_err++; $display("FAIL busy_release got dv=%0b byte=%h want 1 d1", tx_dv, tx_byte); end
        n_cmp++; if (count !== 4'd1) begin n_err++; $display("FAIL busy_count2 got %0d want 1", count); end
        tick();
        finish_frame();
        tick();
        n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hD2) begin n_err++; $display("FAIL busy_second got dv=%0b byte=%h want 1 d2", tx_dv, tx_byte); end
        tick();
        finish_frame();
    endtask

    task automatic test_reset_mid();
        push_byte(8'hE0);
        tx_active = 1'b1;
        push_byte(8'hE1);
        push_byte(8'hE2);
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (count !== 4'd0 || empty !== 1'b1) begin n_err++; $display("FAIL rstmid_count got cnt=%0d empty=%0b want 0 1", count, empty); end
        n_cmp++; if (tx_dv !== 1'b0 || tx_byte !== 8'h00) begin n_err++; $display("FAIL rstmid_tx got dv=%0b byte=%h want 0 00", tx_dv, tx_byte); end
        tx_active = 1'b0;
        tick();
        rst = 1'b1;
        push_byte(8'hE5);
        tick();
        n_cmp++; if (tx_dv !== 1'b1 || tx_byte !== 8'hE5) begin n_err++; $display("FAIL rstmid_resume got dv=%0b byte=%h want 1 e5", tx_dv, tx_byte); end
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0; tx_active = 1'b0; tx_done = 1'b0;
        test_reset();
        test_single_byte();
        test_burst_wrap();
        test_overflow();
        test_flush();
        test_busy_line();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
